// File: rtl/ex_stage_if.sv
// Execute-stage bus: operand sources and controls in, ALU result and flags out.
// master drives operands/controls, slave is the execute stage itself.
interface ex_stage_if;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ImmExt;
    logic [31:0] PC;
    logic        ALUSrc;
    logic        PCtoALU;
    logic [3:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Negative;
    logic        Carry;
    logic        Overflow;
    logic        Less_signed;
    logic        Less_unsigned;
    logic [31:0] ALUResultQ;
    logic [5:0]  FlagsQ;

    modport master (
        output RD1, RD2, ImmExt, PC, ALUSrc, PCtoALU, ALUControl,
        input  ALUResult, Zero, Negative, Carry, Overflow,
               Less_signed, Less_unsigned, ALUResultQ, FlagsQ
    );

    modport slave (
        input  RD1, RD2, ImmExt, PC, ALUSrc, PCtoALU, ALUControl,
        output ALUResult, Zero, Negative, Carry, Overflow,
               Less_signed, Less_unsigned, ALUResultQ, FlagsQ
    );
endinterface

// File: rtl/ex_stage.sv
// RV32 execute stage: operand select, 32-bit ALU with branch flags, and a
// registered copy of result/flags for pipelined or debug consumers.
module ex_stage (
    input  logic   clk,
    input  logic   rst_n,
    ex_stage_if.slave ex
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_PASS = 4'b1111;

    logic [31:0] a, b, res;
    logic [32:0] sum33, diff33;
    logic [4:0]  shamt;
    logic        less_s, less_u, carry, ovf;

    assign a      = ex.PCtoALU ? ex.PC : ex.RD1;
    assign b      = ex.ALUSrc ? ex.ImmExt : ex.RD2;
    assign shamt  = b[4:0];
    assign sum33  = {1'b0, a} + {1'b0, b};
    // Subtract as A + ~B + 1 so bit 32 is the RISC-style "no borrow" carry.
    assign diff33 = {1'b0, a} + {1'b0, ~b} + 33'd1;
    assign less_s = $signed(a) < $signed(b);
    assign less_u = a < b;

    always_comb begin
        res   = 32'd0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (ex.ALUControl)
            OP_ADD: begin
                res   = sum33[31:0];
                carry = sum33[32];
                ovf   = (a[31] == b[31]) && (sum33[31] != a[31]);
            end
            OP_SUB: begin
                res   = diff33[31:0];
                carry = diff33[32];
                ovf   = (a[31] != b[31]) && (diff33[31] != a[31]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  res = {31'd0, less_s};
            OP_SLTU: res = {31'd0, less_u};
            OP_PASS: res = b;
            default: res = 32'd0;
        endcase
    end

    assign ex.ALUResult     = res;
    assign ex.Zero          = (res == 32'd0);
    assign ex.Negative      = res[31];
    assign ex.Carry         = carry;
    assign ex.Overflow      = ovf;
    assign ex.Less_signed   = less_s;
    assign ex.Less_unsigned = less_u;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex.ALUResultQ <= 32'd0;
            ex.FlagsQ     <= 6'd0;
        end else begin
            ex.ALUResultQ <= res;
            ex.FlagsQ     <= {less_u, less_s, ovf, carry, res[31], (res == 32'd0)};
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: hand-computed expectations queued at drive time,
// popped and checked against the combinational and registered outputs.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if bus ();
    ex_stage dut (.clk(clk), .rst_n(rst_n), .ex(bus.slave));

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [5:0]  flags;
    } exp_t;

    exp_t q_comb[$];
    exp_t q_reg[$];
    int errors = 0;
    int checks = 0;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011,
                           XOR_ = 4'b0100, SLL = 4'b0101, SRL = 4'b0110, SRA = 4'b0111,
                           SLT = 4'b1000, SLTU = 4'b1001, PASS = 4'b1111;

    function automatic logic [5:0] flags_now();
        return {bus.Less_unsigned, bus.Less_signed, bus.Overflow,
                bus.Carry, bus.Negative, bus.Zero};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic alusrc, input logic pctoalu, input logic [3:0] op);
        bus.RD1 = rd1; bus.RD2 = rd2; bus.ImmExt = imm; bus.PC = pc;
        bus.ALUSrc = alusrc; bus.PCtoALU = pctoalu; bus.ALUControl = op;
    endtask

    task automatic check_comb();
        exp_t e;
        e = q_comb.pop_front();
        chk({e.tag, ".res"}, bus.ALUResult, e.res);
        chk({e.tag, ".flags"}, {26'd0, flags_now()}, {26'd0, e.flags});
    endtask

    task automatic check_reg();
        exp_t e;
        e = q_reg.pop_front();
        chk({e.tag, ".resQ"}, bus.ALUResultQ, e.res);
        chk({e.tag, ".flagsQ"}, {26'd0, bus.FlagsQ}, {26'd0, e.flags});
    endtask

    // Flags order: {Lu, Ls, Ovf, C, N, Z}
    task automatic step(input string tag, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic alusrc, input logic pctoalu, input logic [3:0] op,
                        input logic [31:0] eres, input logic [5:0] eflags);
        exp_t e;
        @(negedge clk);
        drive(rd1, rd2, imm, pc, alusrc, pctoalu, op);
        e.tag = tag; e.res = eres; e.flags = eflags;
        q_comb.push_back(e);
        q_reg.push_back(e);
        #1 check_comb();
        @(posedge clk);
        #1 check_reg();
    endtask

    initial begin
        exp_t e;
        drive(32'd7, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, ADD);
        // Reset held: registered copies stay clear across edges, comb path live.
        repeat (2) @(posedge clk);
        #1 chk("rst.resQ", bus.ALUResultQ, 32'd0);
        chk("rst.flagsQ", {26'd0, bus.FlagsQ}, 32'd0);
        chk("rst.comb", bus.ALUResult, 32'd12);
        @(posedge clk);
        #1 chk("rst.resQ2", bus.ALUResultQ, 32'd0);

        // Release away from an edge; no capture until the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        e.tag = "post_rst"; e.res = 32'd12; e.flags = 6'b000000;
        q_reg.push_back(e);
        #1 chk("post_rst.preQ", bus.ALUResultQ, 32'd0);
        @(posedge clk);
        #1 check_reg();

        step("add",     32'd7, 32'd5, 0, 0, 0, 0, ADD,  32'd12, 6'b000000);
        step("sub",     32'd7, 32'd5, 0, 0, 0, 0, SUB,  32'd2,  6'b000100);
        step("and",     32'd7, 32'd5, 0, 0, 0, 0, AND_, 32'd5,  6'b000000);
        step("or",      32'd7, 32'd5, 0, 0, 0, 0, OR_,  32'd7,  6'b000000);
        step("xor",     32'd7, 32'd5, 0, 0, 0, 0, XOR_, 32'd2,  6'b000000);
        step("sub_eq",  32'd5, 32'd5, 0, 0, 0, 0, SUB,  32'd0,  6'b000101);
        step("sub_neg", 32'd3, 32'd5, 0, 0, 0, 0, SUB,  32'hFFFFFFFE, 6'b110010);
        step("sll",     32'h80000000, 32'd2,  0, 0, 0, 0, SLL, 32'd0,        6'b010001);
        step("srl",     32'h80000000, 32'd2,  0, 0, 0, 0, SRL, 32'h20000000, 6'b010000);
        step("sra",     32'h80000000, 32'd2,  0, 0, 0, 0, SRA, 32'hE0000000, 6'b010010);
        step("sll34",   32'h80000000, 32'd34, 0, 0, 0, 0, SLL, 32'd0,        6'b010001);
        step("srl34",   32'h80000000, 32'd34, 0, 0, 0, 0, SRL, 32'h20000000, 6'b010000);
        step("sra34",   32'h80000000, 32'd34, 0, 0, 0, 0, SRA, 32'hE0000000, 6'b010010);
        step("slt",     32'hFFFFFFFB, 32'd3,  0, 0, 0, 0, SLT,  32'd1, 6'b010000);
        step("sltu",    32'hFFFFFFF0, 32'h10, 0, 0, 0, 0, SLTU, 32'd0, 6'b010001);
        step("add_ovf", 32'h7FFFFFFF, 32'd1,  0, 0, 0, 0, ADD, 32'h80000000, 6'b001010);
        step("add_cz",  32'hFFFFFFFF, 32'd1,  0, 0, 0, 0, ADD, 32'd0,        6'b010101);
        step("sub_ovf", 32'h80000000, 32'd1,  0, 0, 0, 0, SUB, 32'h7FFFFFFF, 6'b011100);
        step("pass_b",  32'd0, 32'd0, 32'hABCD0000, 0, 1, 0, PASS, 32'hABCD0000, 6'b100010);
        step("pc_add",  32'd9, 32'd9, 32'h20, 32'h100, 1, 1, ADD, 32'h120, 6'b000000);
        step("op1100",  32'd7, 32'd5, 0, 0, 0, 0, 4'b1100, 32'd0, 6'b000001);
        step("op1010",  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 4'b1010, 32'd0, 6'b000001);

        // Mid-run reset: registered copy clears at once, comb path keeps tracking.
        @(negedge clk);
        drive(32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, SUB);
        @(posedge clk);
        #2 chk("mid.preQ", bus.ALUResultQ, 32'hFFFFFFFE);
        rst_n = 1'b0;
        #1 chk("mid.resQ", bus.ALUResultQ, 32'd0);
        chk("mid.flagsQ", {26'd0, bus.FlagsQ}, 32'd0);
        chk("mid.comb", bus.ALUResult, 32'hFFFFFFFE);
        @(posedge clk);
        #1 chk("mid.holdQ", bus.ALUResultQ, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
